tick_period_meter: RTL

Receive-side companion to the team's tick-generating counters. Watches a single-bit tick input, measures the number of clk cycles between successive rising edges, and delivers each measurement on a valid/ready output port. Flags dropped measurements (overrun) and loss of ticks (timeout) with sticky status bits. Sits in the clk domain next to the tick source it monitors.

---
 rtl/tick_period_meter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tick_period_meter.sv
// Measures clk cycles between rising edges of tick and delivers each spacing
// on a single-entry valid/ready port, with sticky overrun and timeout flags.
module tick_period_meter #(
  parameter int BITS    = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            clear,
  output logic [BITS-1:0] period,
  output logic            period_valid,
  input  logic            period_ready,
  output logic            overrun,
  output logic            timeout,
  output logic            active
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [BITS-1:0] TIMEOUT_C = BITS'(TIMEOUT);
  localparam logic [BITS-1:0] ONE_C     = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS-1:0] ZERO_C    = {BITS{1'b0}};

  state_t          state_r;
  state_t          state_s;
  logic            tick_q_r;
  logic [BITS-1:0] cnt_r;
  logic [BITS-1:0] cnt_s;
  logic            edge_s;
  logic            meas_s;
  logic            tout_set_s;
  logic            ovr_set_s;
  logic            xfer_s;
  logic [BITS-1:0] period_s;
  logic            period_valid_s;
  logic            overrun_s;
  logic            timeout_s;

  assign edge_s = tick & ~tick_q_r;
  assign xfer_s = period_valid & period_ready;

  // State and all output registers; reset discards any pending measurement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      tick_q_r     <= 1'b0;
      cnt_r        <= ZERO_C;
      period       <= ZERO_C;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
      active       <= 1'b0;
    end else begin
      state_r      <= state_s;
      tick_q_r     <= tick;
      cnt_r        <= cnt_s;
      period       <= period_s;
      period_valid <= period_valid_s;
      overrun      <= overrun_s;
      timeout      <= timeout_s;
      active       <= (state_s == MEASURE);
    end
  end

  // Next state and counter; an edge exactly at TIMEOUT still counts as a measurement.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    meas_s     = 1'b0;
    tout_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          state_s = MEASURE;
          cnt_s   = ONE_C;
        end else begin
          cnt_s   = ZERO_C;
        end
      end
      MEASURE: begin
        if (edge_s) begin
          meas_s = 1'b1;
          cnt_s  = ONE_C;
        end else if (cnt_r == TIMEOUT_C) begin
          state_s    = IDLE;
          cnt_s      = ZERO_C;
          tout_set_s = 1'b1;
        end else begin
          cnt_s = cnt_r + ONE_C;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO_C;
      end
    endcase
  end

  // Output buffer and sticky flags; a set condition beats clear in the same cycle.
  always_comb begin
    period_s       = period;
    period_valid_s = period_valid;
    ovr_set_s      = 1'b0;
    if (meas_s) begin
      if (!period_valid || xfer_s) begin
        period_s       = cnt_r;
        period_valid_s = 1'b1;
      end else begin
        ovr_set_s = 1'b1;
      end
    end else if (xfer_s) begin
      period_valid_s = 1'b0;
    end else begin
      period_valid_s = period_valid;
    end
    overrun_s = ovr_set_s | (overrun & ~clear);
    timeout_s = tout_set_s | (timeout & ~clear);
  end

endmodule
